// File: rtl/pc_pkg.sv
// ============================================================================
// pc_pkg : shared types and default vectors for the fetch-stage PC sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package pc_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_HOLD = 3'd1,
        SEL_BR   = 3'd2,
        SEL_JMP  = 3'd3,
        SEL_EXC  = 3'd4
    } sel_e;

    localparam logic [31:0] C_DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] C_DEF_EXC_VECTOR   = 32'h0000_0180;

endpackage

`default_nettype wire

// File: rtl/pc_next_mux.sv
// ============================================================================
// pc_next_mux : priority redirect select, branch target and alignment trap
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_next_mux
    import pc_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    INCR       = 4,
    parameter int                    ALIGN_BITS = 2,
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR = DATA_WIDTH'(C_DEF_EXC_VECTOR)
) (
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  stall_i,
    input  logic                  branch_taken_i,
    input  logic [DATA_WIDTH-1:0] branch_base_i,
    input  logic [DATA_WIDTH-1:0] branch_offset_i,
    input  logic                  jump_en_i,
    input  logic [DATA_WIDTH-1:0] jump_target_i,
    input  logic                  exc_req_i,
    output logic [DATA_WIDTH-1:0] pc_add_o,
    output logic [DATA_WIDTH-1:0] next_pc_o,
    output logic                  redirect_o,
    output logic                  misalign_o,
    output logic                  trap_o
);

    localparam logic [DATA_WIDTH-1:0] C_ALIGN_MASK =
        DATA_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    sel_e                  sel;
    logic [DATA_WIDTH-1:0] br_target;
    logic [DATA_WIDTH-1:0] target;
    logic                  target_bad;

    assign pc_add_o  = pc_i + DATA_WIDTH'(INCR);
    assign br_target = branch_base_i + (branch_offset_i << ALIGN_BITS);

    always_comb begin
        sel = SEL_SEQ;
        if (exc_req_i) begin
            sel = SEL_EXC;
        end else if (jump_en_i) begin
            sel = SEL_JMP;
        end else if (branch_taken_i) begin
            sel = SEL_BR;
        end else if (stall_i) begin
            sel = SEL_HOLD;
        end
    end

    // Only the winning target is checked, so a losing branch can never trap.
    assign target     = (sel == SEL_JMP) ? jump_target_i : br_target;
    assign target_bad = |(target & C_ALIGN_MASK);

    always_comb begin
        next_pc_o  = pc_add_o;
        redirect_o = 1'b0;
        misalign_o = 1'b0;
        trap_o     = 1'b0;
        case (sel)
            SEL_SEQ:  next_pc_o = pc_add_o;
            SEL_HOLD: next_pc_o = pc_i;
            SEL_BR, SEL_JMP: begin
                redirect_o = 1'b1;
                if (target_bad) begin
                    next_pc_o  = EXC_VECTOR;
                    misalign_o = 1'b1;
                    trap_o     = 1'b1;
                end else begin
                    next_pc_o = target;
                end
            end
            SEL_EXC: begin
                next_pc_o  = EXC_VECTOR;
                redirect_o = 1'b1;
                trap_o     = 1'b1;
            end
            default: next_pc_o = pc_add_o;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : fetch-stage PC register with redirects, EPC capture and
//                redirect-driven fetch flush tracking
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    INCR         = 4,
    parameter int                    ALIGN_BITS   = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(C_DEF_RESET_VECTOR),
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = DATA_WIDTH'(C_DEF_EXC_VECTOR),
    parameter int                    FLUSH_CYCLES = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  BranchTaken,
    input  logic [DATA_WIDTH-1:0] BranchBase,
    input  logic [DATA_WIDTH-1:0] BranchOffset,
    input  logic                  JumpEn,
    input  logic [DATA_WIDTH-1:0] JumpTarget,
    input  logic                  ExcReq,
    output logic [DATA_WIDTH-1:0] PCResult,
    output logic [DATA_WIDTH-1:0] PCAddResult,
    output logic                  FlushIF,
    output logic                  Misaligned,
    output logic [DATA_WIDTH-1:0] EPC
);

    localparam logic [3:0] C_FLUSH_LOAD = 4'(FLUSH_CYCLES);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic                  mis_q;
    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;

    logic redirect;
    logic misalign;
    logic trap;

    pc_next_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .INCR       (INCR),
        .ALIGN_BITS (ALIGN_BITS),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next (
        .pc_i            (pc_q),
        .stall_i         (Stall),
        .branch_taken_i  (BranchTaken),
        .branch_base_i   (BranchBase),
        .branch_offset_i (BranchOffset),
        .jump_en_i       (JumpEn),
        .jump_target_i   (JumpTarget),
        .exc_req_i       (ExcReq),
        .pc_add_o        (PCAddResult),
        .next_pc_o       (pc_d),
        .redirect_o      (redirect),
        .misalign_o      (misalign),
        .trap_o          (trap)
    );

    assign epc_d = trap ? pc_q : epc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    state_d = FLUSH;
                    cnt_d   = C_FLUSH_LOAD;
                end
            end
            FLUSH: begin
                // A fresh redirect restarts the squash window from the top.
                if (redirect) begin
                    cnt_d = C_FLUSH_LOAD;
                end else if (cnt_q <= 4'd1) begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            mis_q   <= 1'b0;
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= misalign;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PCResult   = pc_q;
    assign EPC        = epc_q;
    assign Misaligned = mis_q;
    assign FlushIF    = (state_q == FLUSH);

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit for the pipeline fetch stage. It replaces a bare PC register and PC+INCR adder pair with one block. The block holds the PC and computes the sequential next address. It selects among exception, jump and branch redirects, supports fetch stall, and tracks redirect-induced fetch flushes with a small state machine. It also traps misaligned targets and captures the exception PC.

Parameters:
DATA_WIDTH, 32, width of PC and all address ports
INCR, 4, sequential increment added to PC each advancing cycle
ALIGN_BITS, 2, low address bits that must be zero; also the branch offset shift amount
RESET_VECTOR, 32'h0000_0000, PC value while Reset is high and on first cycle after
EXC_VECTOR, 32'h0000_0180, PC loaded on exception or misaligned redirect
FLUSH_CYCLES, 1, cycles FlushIF stays high after a redirect (range 1..15)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Stall  input  1  hold PC (sequential advance only)
BranchTaken  input  1  take relative branch this cycle
BranchBase  input  DATA_WIDTH  PC+INCR of the branch instruction (from ID stage)
BranchOffset  input  DATA_WIDTH  sign-extended word offset
JumpEn  input  1  take absolute jump this cycle
JumpTarget  input  DATA_WIDTH  absolute jump address
ExcReq  input  1  exception request
PCResult  output  DATA_WIDTH  current PC (registered)
PCAddResult  output  DATA_WIDTH  PCResult + INCR (combinational)
FlushIF  output  1  high while fetch-stage instructions must be squashed
Misaligned  output  1  one-cycle pulse: a redirect target was misaligned
EPC  output  DATA_WIDTH  PCResult captured on exception/misalign

Behaviour:
- Reset (async, high): PCResult=RESET_VECTOR, EPC=0, FlushIF=0, Misaligned=0, state=RUN, flush counter=0. Reset asserted mid-flush aborts the flush immediately.
- Next-PC priority, evaluated each rising edge:
  - ExcReq first: next=EXC_VECTOR.
  - then JumpEn: next=JumpTarget.
  - then BranchTaken: next=BranchBase + (BranchOffset << ALIGN_BITS).
  - then Stall: PC holds.
  - else: next=PCAddResult.
- Redirects override Stall.
- Arithmetic: all sums modulo 2^DATA_WIDTH. PC wraps, e.g. 32'hFFFF_FFFC+4 -> 0. Shifted offset is truncated to DATA_WIDTH. Negative offsets subtract.
- Alignment: a jump or branch target with any nonzero bit in [ALIGN_BITS-1:0] is misaligned.
  - It is not loaded. The PC loads EXC_VECTOR instead.
  - Misaligned=1 on the following cycle only.
  - EPC=current PCResult, same as for an exception.
- ExcReq: EPC<=PCResult on the same edge. EXC_VECTOR itself is not alignment-checked.
- Redirect means exception, jump, branch or misalign trap. Latency: the new PC is visible on PCResult one cycle after the redirect edge.
- FSM states:
  - RUN: FlushIF=0. A redirect goes to FLUSH and loads counter=FLUSH_CYCLES.
  - FLUSH: FlushIF=1. The counter decrements each cycle and returns to RUN when it reaches 1. A new redirect while in FLUSH reloads the counter to FLUSH_CYCLES.
  - The PC keeps advancing or stalling normally during FLUSH.
- FlushIF and Misaligned are registered. Both assert on the cycle the redirected PC appears.
- Simultaneous ExcReq with a misaligned jump: the exception wins and Misaligned stays 0.
- Simultaneous JumpEn and BranchTaken: the jump wins and the branch target is ignored, including its alignment.

Decomposition:
- Shared package pc_pkg holds:
  - state enum {RUN, FLUSH}.
  - redirect-select encoding {SEL_SEQ, SEL_HOLD, SEL_BR, SEL_JMP, SEL_EXC}.
  - default RESET_VECTOR and EXC_VECTOR constants.
- One natural sub-module: pc_next_mux, a combinational priority select plus target/alignment calculation. It outputs next PC, redirect flag and misalign flag.
- The top holds the PC register, EPC, FSM and counter.

Test Plan:
- Reset then 4 free-run cycles -> PCResult 0,4,8,12,16. PCAddResult always PCResult+4. FlushIF=0.
- Stall high 3 cycles at PC=8 -> PCResult stays 8. Release -> 12.
- BranchBase=32'h20, BranchOffset=-2 (32'hFFFF_FFFE), BranchTaken for 1 cycle:
  - next PCResult=32'h18, FlushIF=1 for 1 cycle.
  - With FLUSH_CYCLES=3: FlushIF=1 for 3 cycles, then 0.
- JumpTarget=32'h102 with JumpEn at PC=32'h40:
  - PCResult=32'h180 next cycle, Misaligned pulse=1 for 1 cycle.
  - EPC=32'h40, FlushIF=1.
- ExcReq+JumpEn+Stall together at PC=32'h60 -> PCResult=32'h180, EPC=32'h60, Misaligned=0. Stall is ignored.
- PC=32'hFFFF_FFFC free-run -> PCResult 0. Reset asserted mid-FLUSH (async, between edges) -> PCResult=0 and FlushIF=0 immediately.
